// File: rtl/result_writeback_nn.sv
// rtl/result_writeback_nn.sv - MAC partial-sum writeback with requantization to output BRAM
module result_writeback_nn #(
    parameter int W         = 8,
    parameter int ACC_W     = 16,
    parameter int N         = 4,
    parameter int N_MACS    = 4,
    parameter int MEM_DEPTH = 256,
    parameter int SHIFT     = 0,
    parameter int RELU      = 0,
    parameter int OUT_BASE  = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic [ACC_W-1:0]               acc_in_0,
    input  logic [ACC_W-1:0]               acc_in_1,
    input  logic [ACC_W-1:0]               acc_in_2,
    input  logic [ACC_W-1:0]               acc_in_3,
    input  logic [N_MACS-1:0]              valid_in,
    input  logic [$clog2(N/2)-1:0]         row_tile,
    output logic [$clog2(MEM_DEPTH)-1:0]   out_bram_addr,
    output logic                           out_bram_en,
    output logic                           out_bram_we,
    output logic [W-1:0]                   out_bram_din,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic [$clog2(N/2):0]           tiles_written
);

    localparam int AW  = $clog2(MEM_DEPTH);
    localparam int TW  = $clog2(N/2);
    localparam int TCW = TW + 1;
    localparam int SW  = ACC_W + 1;

    // Saturation bounds expressed in the widened sum domain
    localparam logic signed [SW-1:0] QMAX = SW'((1 << (W-1)) - 1);
    localparam logic signed [SW-1:0] QMIN = SW'(-(1 << (W-1)));
    localparam logic [TCW-1:0]       TILES_ALL = TCW'(N/2);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_WR0,
        S_WR1
    } state_t;

    state_t              r_state;
    logic [N_MACS-1:0]   r_valid_d;
    logic                r_armed;
    logic [ACC_W-1:0]    r_acc0;
    logic [ACC_W-1:0]    r_acc1;
    logic [ACC_W-1:0]    r_acc2;
    logic [ACC_W-1:0]    r_acc3;
    logic [TW-1:0]       r_tile;
    logic [W-1:0]        r_q1;
    logic [AW-1:0]       r_addr;
    logic                r_en;
    logic                r_we;
    logic [W-1:0]        r_din;
    logic                r_done;
    logic                r_overflow;
    logic [TCW-1:0]      r_tiles;

    logic                w_capture;
    logic signed [SW-1:0] w_y0;
    logic signed [SW-1:0] w_y1;
    logic [31:0]         w_lin0;
    logic [AW-1:0]       w_addr0;
    logic [AW-1:0]       w_addr1;

    // Shift, optional ReLU, then clamp to the signed W-bit range
    function automatic logic [W-1:0] requant(input logic signed [SW-1:0] s);
        logic signed [SW-1:0] v;
        v = s >>> SHIFT;
        if (RELU != 0 && v < 0) begin
            v = '0;
        end
        if (v > QMAX) begin
            requant = QMAX[W-1:0];
        end else if (v < QMIN) begin
            requant = QMIN[W-1:0];
        end else begin
            requant = v[W-1:0];
        end
    endfunction

    // A tile is taken only on the rising edge of the all-MACs-valid condition
    assign w_capture = r_armed & (&valid_in) & ~(&r_valid_d);

    // One extra bit keeps the column-half sums exact
    assign w_y0 = $signed({r_acc0[ACC_W-1], r_acc0}) + $signed({r_acc1[ACC_W-1], r_acc1});
    assign w_y1 = $signed({r_acc2[ACC_W-1], r_acc2}) + $signed({r_acc3[ACC_W-1], r_acc3});

    // Row addresses wrap around the output memory
    assign w_lin0  = 32'(OUT_BASE) + 32'({r_tile, 1'b0});
    assign w_addr0 = AW'(w_lin0 % 32'(MEM_DEPTH));
    assign w_addr1 = AW'((w_lin0 + 32'd1) % 32'(MEM_DEPTH));

    assign out_bram_addr = r_addr;
    assign out_bram_en   = r_en;
    assign out_bram_we   = r_we;
    assign out_bram_din  = r_din;
    assign busy          = (r_state != S_IDLE);
    assign done          = r_done;
    assign overflow      = r_overflow;
    assign tiles_written = r_tiles;

    // Capture / sum / two-write sequencer with registered BRAM port and status
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_valid_d  <= '0;
            r_armed    <= 1'b0;
            r_acc0     <= '0;
            r_acc1     <= '0;
            r_acc2     <= '0;
            r_acc3     <= '0;
            r_tile     <= '0;
            r_q1       <= '0;
            r_addr     <= '0;
            r_en       <= 1'b0;
            r_we       <= 1'b0;
            r_din      <= '0;
            r_done     <= 1'b0;
            r_overflow <= 1'b0;
            r_tiles    <= '0;
        end else begin
            r_valid_d <= valid_in;
            r_done    <= 1'b0;
            if (start) begin
                r_state    <= S_IDLE;
                r_armed    <= 1'b1;
                r_overflow <= 1'b0;
                r_tiles    <= '0;
                r_en       <= 1'b0;
                r_we       <= 1'b0;
            end else begin
                if (w_capture && r_state != S_IDLE) begin
                    r_overflow <= 1'b1;
                end
                case (r_state)
                    S_IDLE: begin
                        if (w_capture) begin
                            r_acc0  <= acc_in_0;
                            r_acc1  <= acc_in_1;
                            r_acc2  <= acc_in_2;
                            r_acc3  <= acc_in_3;
                            r_tile  <= row_tile;
                            r_state <= S_SUM;
                        end
                    end
                    S_SUM: begin
                        r_q1    <= requant(w_y1);
                        r_din   <= requant(w_y0);
                        r_addr  <= w_addr0;
                        r_en    <= 1'b1;
                        r_we    <= 1'b1;
                        r_state <= S_WR0;
                    end
                    S_WR0: begin
                        r_din   <= r_q1;
                        r_addr  <= w_addr1;
                        r_state <= S_WR1;
                    end
                    S_WR1: begin
                        r_en    <= 1'b0;
                        r_we    <= 1'b0;
                        r_tiles <= r_tiles + 1'b1;
                        if (r_tiles + 1'b1 == TILES_ALL) begin
                            r_done  <= 1'b1;
                            r_armed <= 1'b0;
                        end
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_result_writeback_nn.sv
// tb/tb_result_writeback_nn.sv - scoreboard bench for result_writeback_nn (three parameter sets)
module tb_result_writeback_nn;

    localparam int SHF  [3] = '{0, 2, 0};
    localparam int RLU  [3] = '{0, 0, 1};
    localparam int BASE [3] = '{0, 3, 254};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [15:0] a0, a1, a2, a3;
    logic [3:0]  vin;
    logic [0:0]  tin;

    wire [2:0][7:0] addr;
    wire [2:0][7:0] din;
    wire [2:0]      en, we, busy, done, ovf;
    wire [2:0][1:0] tw;

    result_writeback_nn #(.W(8), .ACC_W(16), .N(4), .N_MACS(4), .MEM_DEPTH(256),
        .SHIFT(SHF[0]), .RELU(RLU[0]), .OUT_BASE(BASE[0])) u_a (
        .clk(clk), .rst(rst), .start(start),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3),
        .valid_in(vin), .row_tile(tin),
        .out_bram_addr(addr[0]), .out_bram_en(en[0]), .out_bram_we(we[0]),
        .out_bram_din(din[0]), .busy(busy[0]), .done(done[0]),
        .overflow(ovf[0]), .tiles_written(tw[0]));

    result_writeback_nn #(.W(8), .ACC_W(16), .N(4), .N_MACS(4), .MEM_DEPTH(256),
        .SHIFT(SHF[1]), .RELU(RLU[1]), .OUT_BASE(BASE[1])) u_b (
        .clk(clk), .rst(rst), .start(start),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3),
        .valid_in(vin), .row_tile(tin),
        .out_bram_addr(addr[1]), .out_bram_en(en[1]), .out_bram_we(we[1]),
        .out_bram_din(din[1]), .busy(busy[1]), .done(done[1]),
        .overflow(ovf[1]), .tiles_written(tw[1]));

    result_writeback_nn #(.W(8), .ACC_W(16), .N(4), .N_MACS(4), .MEM_DEPTH(256),
        .SHIFT(SHF[2]), .RELU(RLU[2]), .OUT_BASE(BASE[2])) u_c (
        .clk(clk), .rst(rst), .start(start),
        .acc_in_0(a0), .acc_in_1(a1), .acc_in_2(a2), .acc_in_3(a3),
        .valid_in(vin), .row_tile(tin),
        .out_bram_addr(addr[2]), .out_bram_en(en[2]), .out_bram_we(we[2]),
        .out_bram_din(din[2]), .busy(busy[2]), .done(done[2]),
        .overflow(ovf[2]), .tiles_written(tw[2]));

    typedef struct {
        int             due;
        bit             is_done;
        logic [2:0][7:0] a;
        logic [2:0][7:0] d;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    int   m_free = 0;
    int   m_arm_until = -1;
    int   m_tiles = 0;
    bit   m_ovf = 1'b0;
    bit   m_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got 0x%0h want 0x%0h", nm, i, cyc, act, exp);
        end
    endtask

    function automatic logic [7:0] ref_q(int s, int i);
        int v;
        v = s >>> SHF[i];
        if (RLU[i] != 0 && v < 0) v = 0;
        if (v > 127) v = 127;
        if (v < -128) v = -128;
        return 8'(v);
    endfunction

    function automatic void cancel(int e);
        while (sb.size() > 0 && sb[sb.size()-1].due >= e) void'(sb.pop_back());
    endfunction

    function automatic void accept(int e);
        exp_t w0, w1, dn;
        int s0, s1;
        s0 = int'($signed(a0)) + int'($signed(a1));
        s1 = int'($signed(a2)) + int'($signed(a3));
        for (int i = 0; i < 3; i++) begin
            w0.a[i] = 8'((BASE[i] + 2 * int'(tin)) % 256);
            w1.a[i] = 8'((BASE[i] + 2 * int'(tin) + 1) % 256);
            w0.d[i] = ref_q(s0, i);
            w1.d[i] = ref_q(s1, i);
            dn.a[i] = 8'd0;
            dn.d[i] = 8'd0;
        end
        w0.due = e + 1; w0.is_done = 1'b0;
        w1.due = e + 2; w1.is_done = 1'b0;
        sb.push_back(w0);
        sb.push_back(w1);
        m_tiles++;
        m_free = e + 4;
        if (m_tiles == 2) begin
            dn.due = e + 3; dn.is_done = 1'b1;
            sb.push_back(dn);
            m_arm_until = e + 3;
        end
    endfunction

    // Reference model: decides what the next clock edge does to the write stream
    function automatic void step();
        int e;
        bit all, cap;
        e = cyc + 1;
        if (rst) begin
            cancel(e);
            m_arm_until = -1; m_tiles = 0; m_ovf = 1'b0; m_prev = 1'b0; m_free = 0;
        end else begin
            all = &vin;
            cap = (e <= m_arm_until) && all && !m_prev;
            m_prev = all;
            if (start) begin
                cancel(e);
                m_arm_until = 1 << 30; m_tiles = 0; m_ovf = 1'b0; m_free = 0;
            end else if (cap) begin
                if (e >= m_free) accept(e);
                else m_ovf = 1'b1;
            end
        end
    endfunction

    task automatic tick();
        step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1; vin = 4'h0;
        tick();
        start = 1'b0;
    endtask

    task automatic set_acc(int x0, int x1, int x2, int x3);
        a0 = 16'(x0); a1 = 16'(x1); a2 = 16'(x2); a3 = 16'(x3);
    endtask

    task automatic send(int t, int x0, int x1, int x2, int x3);
        tin = 1'(t);
        set_acc(x0, x1, x2, x3);
        vin = 4'hF;
        tick();
        vin = 4'h0;
        repeat (3) tick();
    endtask

    task automatic idle_status(bit chk_din);
        vin = 4'h0; start = 1'b0;
        repeat (5) tick();
        for (int i = 0; i < 3; i++) begin
            chk("busy", i, 32'(busy[i]), 32'd0);
            chk("overflow", i, 32'(ovf[i]), 32'(m_ovf));
            chk("tiles_written", i, 32'(tw[i]), 32'(m_tiles));
            if (chk_din) begin
                chk("rst_addr", i, 32'(addr[i]), 32'd0);
                chk("rst_din", i, 32'(din[i]), 32'd0);
            end
        end
    endtask

    // Monitor: every cycle the BRAM port and done must match the queue head or be quiet
    always @(negedge clk) begin
        exp_t x;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            x = sb.pop_front();
            for (int i = 0; i < 3; i++) begin
                if (x.is_done) begin
                    chk("done", i, 32'(done[i]), 32'd1);
                    chk("we_at_done", i, 32'({en[i], we[i]}), 32'd0);
                end else begin
                    chk("en_we", i, 32'({en[i], we[i]}), 32'd3);
                    chk("addr", i, 32'(addr[i]), 32'(x.a[i]));
                    chk("din", i, 32'(din[i]), 32'(x.d[i]));
                    chk("done_at_wr", i, 32'(done[i]), 32'd0);
                end
            end
        end else begin
            for (int i = 0; i < 3; i++)
                chk("quiet", i, 32'({en[i], we[i], done[i]}), 32'd0);
        end
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; vin = 4'h0; tin = 1'b0;
        set_acc(0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        idle_status(1'b1);

        // not armed: capture ignored, no overflow
        send(0, 5, 5, 5, 5);
        idle_status(1'b1);

        // basic two-tile run, then a disarmed capture
        do_start();
        send(0, 3, 4, -5, 2);
        send(1, 10, 0, 0, -1);
        idle_status(1'b0);
        send(1, 1, 1, 1, 1);
        idle_status(1'b0);

        // saturation and ReLU values
        do_start();
        send(0, 400, 200, -400, -300);
        send(1, -5, 1, 6, 1);
        idle_status(1'b0);

        // second rise two cycles after the first is dropped
        do_start();
        tin = 1'b0; set_acc(1, 2, 3, 4);
        vin = 4'hF; tick();
        vin = 4'h0; tick();
        vin = 4'hF; tick();
        idle_status(1'b0);
        do_start();
        idle_status(1'b0);

        // reset while the first row is being written
        do_start();
        tin = 1'b1; set_acc(-20, 7, 9, 9);
        vin = 4'hF; tick();
        vin = 4'h0; tick();
        rst = 1'b1; tick();
        rst = 1'b0;
        idle_status(1'b1);
        do_start();
        send(0, 100, -1, 2, 2);
        send(1, -3000, 5, 300, 300);
        idle_status(1'b0);

        // level-high valid counts once; tile 1 exercises address wrap
        do_start();
        tin = 1'b1; set_acc(11, 12, -13, -14);
        vin = 4'hF;
        repeat (10) tick();
        vin = 4'h0; tick();
        send(0, 1, 2, 3, 4);
        idle_status(1'b0);

        // randomized runs with gaps, partial valids and back-to-back rises
        repeat (40) begin
            do_start();
            n = $urandom_range(1, 4);
            repeat (n) begin
                tin = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 1) == 1)
                    set_acc(int'($signed(16'($urandom))), int'($signed(16'($urandom))),
                            int'($signed(16'($urandom))), int'($signed(16'($urandom))));
                else
                    set_acc($urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300,
                            $urandom_range(0, 600) - 300, $urandom_range(0, 600) - 300);
                vin = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                tick();
                vin = 4'h0;
                repeat ($urandom_range(0, 5)) tick();
            end
            idle_status(1'b0);
        end

        chk("scoreboard_drained", 0, 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
